// File: rtl/utf8_stream_arbiter.sv
// Two-requester round-robin arbiter that encodes each granted code point as UTF-8
// and streams it out byte by byte. One character is fully emitted before the next grant.
module utf8_stream_arbiter #(
  parameter bit REPLACE_INVALID = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [20:0] req0_cp,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [20:0] req1_cp,
  output logic        req1_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        out_src,
  input  logic        out_ready,
  output logic        err,
  output logic        state_dbg
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q;
  logic            src_q;
  logic [20:0]     cp_q;
  logic [3:0][7:0] bytes_q;
  logic [2:0]      len_q;
  logic [1:0]      idx_q;
  logic            err_q;

  logic            grant;
  logic            xfer;
  logic            last_byte;
  logic [20:0]     sel_cp;
  logic [20:0]     enc_cp;
  logic            invalid;
  logic [3:0][7:0] enc_bytes;
  logic [2:0]      enc_len;

  // Handshake: a requester transfers when its valid and ready are both high.
  // Ready is only offered in IDLE, outside reset, to the granted requester with valid high.
  assign grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign xfer       = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = xfer && !grant;
  assign req1_ready = xfer && grant;

  assign last_byte  = ({1'b0, idx_q} + 3'd1) == len_q;
  assign out_src    = src_q;
  assign err        = err_q;
  assign state_dbg  = (state_q == EMIT);

  always_comb begin
    sel_cp    = grant ? req1_cp : req0_cp;
    invalid   = ((sel_cp >= 21'h00D800) && (sel_cp <= 21'h00DFFF)) || (sel_cp > 21'h10FFFF);
    enc_cp    = invalid ? 21'h00FFFD : sel_cp;
    enc_bytes = '0;
    enc_len   = 3'd1;
    if (enc_cp < 21'h000080) begin
      enc_len      = 3'd1;
      enc_bytes[0] = {1'b0, enc_cp[6:0]};
    end else if (enc_cp < 21'h000800) begin
      enc_len      = 3'd2;
      enc_bytes[0] = {3'b110, enc_cp[10:6]};
      enc_bytes[1] = {2'b10, enc_cp[5:0]};
    end else if (enc_cp < 21'h010000) begin
      enc_len      = 3'd3;
      enc_bytes[0] = {4'b1110, enc_cp[15:12]};
      enc_bytes[1] = {2'b10, enc_cp[11:6]};
      enc_bytes[2] = {2'b10, enc_cp[5:0]};
    end else begin
      enc_len      = 3'd4;
      enc_bytes[0] = {5'b11110, enc_cp[20:18]};
      enc_bytes[1] = {2'b10, enc_cp[17:12]};
      enc_bytes[2] = {2'b10, enc_cp[11:6]};
      enc_bytes[3] = {2'b10, enc_cp[5:0]};
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        // Dropped invalid code points keep the block in IDLE.
        if (xfer && (!invalid || REPLACE_INVALID)) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_byte  = bytes_q[idx_q];
        out_last  = last_byte;
        if (out_ready && last_byte) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      src_q        <= 1'b0;
      cp_q         <= '0;
      bytes_q      <= '0;
      len_q        <= 3'd1;
      idx_q        <= 2'd0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= xfer && invalid;
      if (xfer) begin
        last_grant_q <= grant;
        src_q        <= grant;
        cp_q         <= sel_cp;
        bytes_q      <= enc_bytes;
        len_q        <= enc_len;
        idx_q        <= 2'd0;
      end else if (out_valid && out_ready) begin
        idx_q <= last_byte ? 2'd0 : idx_q + 2'd1;
      end
    end
  end

  // The latched code point is kept for debug visibility alongside the encoded bytes.
  logic cp_q_unused;
  assign cp_q_unused = ^cp_q;

endmodule

// File: tb/tb_utf8_stream_arbiter.sv
// Randomized bench for utf8_stream_arbiter: a queue-based reference model checks every cycle,
// directed scenarios pin the model with literal byte sequences; a second instance covers dropping.
module tb_utf8_stream_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [20:0] req0_cp, req1_cp;
  logic        out_valid, out_last, out_src, out_ready, err, state_dbg;
  logic [7:0]  out_byte;

  logic        d_rst = 1'b1;
  logic        d_req0_valid = 1'b0, d_req1_valid = 1'b0, d_req0_ready, d_req1_ready;
  logic [20:0] d_req0_cp = '0, d_req1_cp = '0;
  logic        d_out_valid, d_out_last, d_out_src, d_err, d_state_dbg;
  logic        d_out_ready = 1'b1;
  logic [7:0]  d_out_byte;

  utf8_stream_arbiter #(.REPLACE_INVALID(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cp(req0_cp), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cp(req1_cp), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .err(err), .state_dbg(state_dbg)
  );

  utf8_stream_arbiter #(.REPLACE_INVALID(1'b0)) dut_drop (
    .clk(clk), .rst(d_rst),
    .req0_valid(d_req0_valid), .req0_cp(d_req0_cp), .req0_ready(d_req0_ready),
    .req1_valid(d_req1_valid), .req1_cp(d_req1_cp), .req1_ready(d_req1_ready),
    .out_valid(d_out_valid), .out_byte(d_out_byte), .out_last(d_out_last), .out_src(d_out_src),
    .out_ready(d_out_ready), .err(d_err), .state_dbg(d_state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0]  exp_q[$];   // {src, last, byte}
  logic [9:0]  got_q[$];
  logic [9:0]  lit[$];
  logic [20:0] src0_q[$];
  logic [20:0] src1_q[$];
  logic        m_last = 1'b1;
  logic        m_err_pend = 1'b0;
  logic        hs0 = 1'b0, hs1 = 1'b0;
  int          err_cnt = 0;
  int          gap_pct = 0;
  int          out_mode = 0;

  function automatic bit is_invalid(input int unsigned cp);
    return (cp >= 32'hD800 && cp <= 32'hDFFF) || cp > 32'h10FFFF;
  endfunction

  task automatic push_char(input int unsigned cp, input logic src);
    int unsigned v;
    int          n;
    logic [7:0]  b[4];
    v = is_invalid(cp) ? 32'hFFFD : cp;
    n = (v < 32'h80) ? 1 : (v < 32'h800) ? 2 : (v < 32'h10000) ? 3 : 4;
    for (int i = 0; i < 4; i++) b[i] = 8'h00;
    for (int i = n - 1; i >= 1; i--) begin
      b[i] = 8'h80 | 8'(v & 32'h3F);
      v = v >> 6;
    end
    case (n)
      1:       b[0] = 8'(v);
      2:       b[0] = 8'hC0 | 8'(v);
      3:       b[0] = 8'hE0 | 8'(v);
      default: b[0] = 8'hF0 | 8'(v);
    endcase
    for (int i = 0; i < n; i++) exp_q.push_back({src, (i == n - 1), b[i]});
  endtask

  always @(negedge clk) begin : model
    logic        e0, e1, g, busy;
    logic [9:0]  f;
    int unsigned cp;
    busy = (exp_q.size() > 0);
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst && !busy && (req0_valid || req1_valid)) begin
      g  = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e0 = !g;
      e1 = g;
    end
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("err", err, m_err_pend);
    if (busy) begin
      f = exp_q[0];
      chk("out_valid", out_valid, 1);
      chk("out_byte", out_byte, f[7:0]);
      chk("out_last", out_last, f[8]);
      chk("out_src", out_src, f[9]);
      if (out_ready) void'(exp_q.pop_front());
    end else begin
      chk("idle_out_valid", out_valid, 0);
      chk("idle_out_byte", out_byte, 0);
      chk("idle_out_last", out_last, 0);
    end
    if (out_valid && out_ready) got_q.push_back({out_src, out_last, out_byte});
    if (err) err_cnt++;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (rst) begin
      exp_q.delete();
      m_last     = 1'b1;
      m_err_pend = 1'b0;
    end else begin
      m_err_pend = 1'b0;
      if (e0 || e1) begin
        cp = e1 ? req1_cp : req0_cp;
        push_char(cp, e1);
        m_last     = e1;
        m_err_pend = is_invalid(cp);
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin : drv0
    req0_valid = 1'b0;
    req0_cp    = '0;
    forever begin
      @(posedge clk); #1;
      if (hs0) begin
        void'(src0_q.pop_front());
        req0_valid = 1'b0;
      end
      if (!req0_valid && src0_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        req0_valid = 1'b1;
        req0_cp    = src0_q[0];
      end
    end
  end

  initial begin : drv1
    req1_valid = 1'b0;
    req1_cp    = '0;
    forever begin
      @(posedge clk); #1;
      if (hs1) begin
        void'(src1_q.pop_front());
        req1_valid = 1'b0;
      end
      if (!req1_valid && src1_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        req1_valid = 1'b1;
        req1_cp    = src1_q[0];
      end
    end
  end

  initial begin : drv_out
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = ($urandom_range(0, 2) != 0);
        default: ;
      endcase
    end
  end

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while ((src0_q.size() > 0 || src1_q.size() > 0 || req0_valid || req1_valid ||
                exp_q.size() > 0) && c < budget);
    chk("drain_within_budget", (c < budget), 1);
    @(negedge clk); #1;
  endtask

  task automatic chk_lit(input string name);
    chk({name, "_count"}, got_q.size(), lit.size());
    for (int i = 0; i < lit.size(); i++)
      chk({name, "_entry"}, (i < got_q.size()) ? got_q[i] : 10'h000, lit[i]);
  endtask

  function automatic logic [20:0] rand_cp();
    int unsigned bnd[12];
    bnd = '{32'h0, 32'h7F, 32'h80, 32'h7FF, 32'h800, 32'hD7FF,
            32'hD800, 32'hDFFF, 32'hE000, 32'hFFFF, 32'h10000, 32'h10FFFF};
    case ($urandom_range(0, 6))
      0:       return 21'($urandom_range(0, 32'h7F));
      1:       return 21'($urandom_range(32'h80, 32'h7FF));
      2:       return 21'($urandom_range(32'h800, 32'hFFFF));
      3:       return 21'($urandom_range(32'hD800, 32'hDFFF));
      4:       return 21'($urandom_range(32'h10000, 32'h10FFFF));
      5:       return 21'($urandom_range(32'h110000, 32'h1FFFFF));
      default: return 21'(bnd[$urandom_range(0, 11)]);
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int e0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    d_rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_byte", out_byte, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_src", out_src, 0);
    chk("reset_err", err, 0);

    // single ASCII byte from req0
    got_q.delete();
    src0_q.push_back(21'h000041);
    wait_idle(200);
    lit = '{10'h141};
    chk_lit("ascii_41");

    // 4-byte character with stalls
    got_q.delete();
    out_mode = 1;
    src1_q.push_back(21'h01F600);
    wait_idle(200);
    lit = '{10'h2F0, 10'h29F, 10'h298, 10'h380};
    chk_lit("emoji_stall");
    out_mode = 0;

    // both requesters continuously valid from reset: round-robin, no interleaving
    @(posedge clk); #1;
    rst = 1'b1;
    src0_q.push_back(21'h0000E9);
    src0_q.push_back(21'h0000E9);
    src1_q.push_back(21'h0020AC);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    wait_idle(300);
    lit = '{10'h0C3, 10'h1A9, 10'h2E2, 10'h282, 10'h3AC, 10'h0C3, 10'h1A9};
    chk_lit("round_robin");

    // surrogate replaced by U+FFFD with an err pulse
    got_q.delete();
    e0 = err_cnt;
    src0_q.push_back(21'h00D800);
    wait_idle(200);
    lit = '{10'h0EF, 10'h0BF, 10'h1BD};
    chk_lit("replace_d800");
    chk("replace_err_pulses", err_cnt - e0, 1);

    // reset after the 2nd byte of U+20AC aborts the character
    got_q.delete();
    src1_q.push_back(21'h0020AC);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (got_q.size() >= 2) break;
    end
    out_mode  = 3;
    out_ready = 1'b0;
    rst       = 1'b1;
    src0_q.push_back(21'h000041);
    src1_q.push_back(21'h000042);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst      = 1'b0;
    out_mode = 0;
    wait_idle(200);
    lit = '{10'h2E2, 10'h282, 10'h141, 10'h342};
    chk_lit("reset_abort");

    // randomized traffic
    gap_pct  = 30;
    out_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0) src0_q.push_back(rand_cp());
      else src1_q.push_back(rand_cp());
    end
    wait_idle(20000);
    gap_pct  = 0;
    out_mode = 0;

    // dropping instance: invalid code points produce only an err pulse
    @(posedge clk); #1;
    d_req0_valid = 1'b1;
    d_req0_cp    = 21'h110000;
    @(negedge clk);
    chk("drop_ready0", d_req0_ready, 1);
    chk("drop_ready1", d_req1_ready, 0);
    @(posedge clk); #1;
    d_req0_valid = 1'b0;
    @(negedge clk);
    chk("drop_err_pulse", d_err, 1);
    chk("drop_no_output", d_out_valid, 0);
    @(posedge clk); #1;
    d_req1_valid = 1'b1;
    d_req1_cp    = 21'h000041;
    @(negedge clk);
    chk("drop_err_cleared", d_err, 0);
    chk("drop_back_idle_ready", d_req1_ready, 1);
    chk("drop_idle_valid", d_out_valid, 0);
    @(posedge clk); #1;
    d_req1_valid = 1'b0;
    @(negedge clk);
    chk("drop_next_valid", d_out_valid, 1);
    chk("drop_next_byte", d_out_byte, 8'h41);
    chk("drop_next_last", d_out_last, 1);
    chk("drop_next_src", d_out_src, 1);
    @(posedge clk); #1;
    d_req0_valid = 1'b1;
    d_req0_cp    = 21'h00DFFF;
    @(negedge clk);
    chk("drop_surr_ready", d_req0_ready, 1);
    @(posedge clk); #1;
    d_req0_valid = 1'b0;
    @(negedge clk);
    chk("drop_surr_err", d_err, 1);
    chk("drop_surr_no_output", d_out_valid, 0);
    @(negedge clk);
    chk("drop_surr_stays_idle", d_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/utf8_stream_arbiter.md
UTF8_STREAM_ARBITER -- requirements
Module: utf8_stream_arbiter

Interface
REQ-001 SHALL have parameter REPLACE_INVALID, default 1: 1 = invalid code points encoded as U+FFFD (EF BF BD); 0 = invalid code points dropped with no output bytes.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 offers a code point.
REQ-005 SHALL have port req0_cp  input  21  requester 0 code point.
REQ-006 SHALL have port req0_ready  output  1  requester 0 code point accepted this cycle.
REQ-007 SHALL have ports req1_valid, req1_cp, req1_ready, identical to the req0_* ports, for requester 1.
REQ-008 SHALL have port out_valid  output  1  out_byte is valid.
REQ-009 SHALL have port out_byte  output  8  current UTF-8 byte.
REQ-010 SHALL have port out_last  output  1  out_byte is the final byte of its character.
REQ-011 SHALL have port out_src  output  1  requester index that owns the current character.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_byte.
REQ-013 SHALL have port err  output  1  one-cycle pulse: an invalid code point was accepted.

Function
REQ-014 SHALL implement two states: IDLE and EMIT.
REQ-015 In IDLE, reqN_ready SHALL be high only for the granted requester and only when its valid is high; a transfer occurs when valid and ready are both high.
REQ-016 Grant: exactly one valid -> that requester; both valid -> the requester that was not granted last (round-robin); none valid -> no grant.
REQ-017 The last-grant pointer SHALL update only on a transfer.
REQ-018 On a transfer, SHALL latch the code point, the source index, the encoded bytes and the length, then enter EMIT on the next cycle.
REQ-019 Length: 0x000000-0x00007F -> 1 byte; 0x000080-0x0007FF -> 2; 0x000800-0x00FFFF -> 3; 0x010000-0x10FFFF -> 4.
REQ-020 Byte encoding: lead byte 0xxxxxxx / 110xxxxx / 1110xxxx / 11110xxx; continuation bytes 10xxxxxx; payload bits most significant first.
REQ-021 Invalid code points: 0x00D800-0x00DFFF and values above 0x10FFFF.
REQ-022 On an invalid code point, err SHALL pulse in the cycle after the transfer; with REPLACE_INVALID=1, EMIT SHALL output EF BF BD; with REPLACE_INVALID=0, the block SHALL stay in IDLE and output no bytes.
REQ-023 In EMIT: out_valid=1, out_byte=byte[idx], out_src=latched source, out_last=(idx==len-1); both ready outputs=0.
REQ-024 When out_valid and out_ready are both high, idx SHALL advance; on the last byte the block SHALL return to IDLE.
REQ-025 While out_ready is low, out_byte, out_last and out_src SHALL hold steady.
REQ-026 Bytes of different characters SHALL never interleave; a character, once granted, SHALL be emitted completely before the next grant.
REQ-027 Latency: transfer at cycle N -> first byte valid at N+1; after the last byte handshake, the next transfer is possible in the following IDLE cycle.
REQ-028 Outside EMIT: out_valid=0, out_last=0, out_byte=0x00.

Reset
REQ-029 With rst high at a clock edge, the block SHALL enter IDLE with out_valid=0, out_byte=0x00, out_last=0, out_src=0, err=0, idx=0, and the last-grant pointer=1, so requester 0 wins the first tie.
REQ-030 A reset during EMIT SHALL abort the character; no remaining bytes of it SHALL be emitted.
REQ-031 req0_ready and req1_ready SHALL be 0 in every cycle in which rst is high.

Verification
REQ-032 req0 sends 0x000041, out_ready=1 -> single byte 0x41, out_last=1, out_src=0, first byte one cycle after the transfer.
REQ-033 req1 sends 0x01F600 with out_ready toggling 1/0 -> bytes F0 9F 98 80, each held stable while stalled, out_last only on 0x80.
REQ-034 Both requesters valid continuously after reset, req0=0x0000E9, req1=0x0020AC -> C3 A9 (src 0), then E2 82 AC (src 1), then src 0 again; no interleaving.
REQ-035 REPLACE_INVALID=1, req0 sends 0x00D800 -> err pulse, bytes EF BF BD; REPLACE_INVALID=0, req0 sends 0x110000 -> err pulse, no output, back in IDLE.
REQ-036 rst asserted after the 2nd byte of 0x0020AC -> out_valid=0 on the next cycle, no 0xAC byte; the next tie is granted to req0.
